// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle CPU control unit.
package cpu_pkg;

    // Instruction-sequencing states
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_FETCH2 = 4'd2,
        S_MEMRD  = 4'd3,
        S_WB_IMM = 4'd4,
        S_MEMWR  = 4'd5,
        S_JUMP   = 4'd6,
        S_MOV    = 4'd7,
        S_EXEC   = 4'd8,
        S_ALU_WB = 4'd9
    } state_t;

    // Opcodes in ir[7:5]; MOV and ALU ignore ir[5]
    localparam logic [2:0] OP_LDI = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_STA = 3'b010;
    localparam logic [2:0] OP_JMP = 3'b011;
    localparam logic [2:0] OP_MOV = 3'b100;
    localparam logic [2:0] OP_ALU = 3'b110;

    // Jump condition codes in di[2:1]
    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_C      = 2'b01;
    localparam logic [1:0] COND_Z      = 2'b10;
    localparam logic [1:0] COND_N      = 2'b11;

endpackage

// File: rtl/branch_cond.sv
// Jump-condition evaluator: selects one CZN flag (or always-true) by cond code.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [1:0] i_cond,
    input  logic [2:0] i_czn,
    output logic       o_taken
);

    // Condition mux; czn bit order is [0]=C, [1]=Z, [2]=N
    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_ALWAYS: o_taken = 1'b1;
            COND_C:      o_taken = i_czn[0];
            COND_Z:      o_taken = i_czn[1];
            COND_N:      o_taken = i_czn[2];
            default:     o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Multicycle control unit: sequencing FSM plus Moore output decoder.
// All strobes are forced low while rst is asserted.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir,
    input  logic [4:0] di,
    input  logic [2:0] czn,
    output logic       ld_PC,
    output logic       ld_IR,
    output logic       ld_DI,
    output logic       ld_TR,
    output logic       ld_ALU,
    output logic       ld_CZN,
    output logic       sel_MEM_src_PC,
    output logic       sel_MEM_src_TR,
    output logic       mem_write,
    output logic       sel_IR_3_2,
    output logic       sel_IR_4_3,
    output logic       write_reg_en,
    output logic       sel_RF_write_src_TR_12_5,
    output logic       sel_writeSRC_reg1,
    output logic       sel_writeSRC_ALU,
    output logic       sel_ALU_src_reg1,
    output logic       sel_ALU_src_TR,
    output logic       sel_CZN_src_ALU,
    output logic       sel_CZN_src_RF,
    output logic       sel_PC_src_JUMP,
    output logic       instr_done
);

    state_t r_state;
    state_t w_next;
    logic   w_taken;
    logic   w_unused;

    // Register fields consumed only by the data path
    assign w_unused = ^{ir[4:0], di[4:3], di[0]};

    branch_cond u_branch_cond (
        .i_cond  (di[2:1]),
        .i_czn   (czn),
        .o_taken (w_taken)
    );

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_FETCH;
        else      r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (!ir[7])                  w_next = S_FETCH2;
                else if (ir[7:6] == OP_MOV[2:1]) w_next = S_MOV;
                else                         w_next = S_EXEC;
            end
            S_FETCH2: begin
                case (ir[7:5])
                    OP_LDI:  w_next = S_WB_IMM;
                    OP_LDA:  w_next = S_MEMRD;
                    OP_STA:  w_next = S_MEMWR;
                    OP_JMP:  w_next = S_JUMP;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMRD:  w_next = S_WB_IMM;
            S_EXEC:   w_next = S_ALU_WB;
            default:  w_next = S_FETCH;
        endcase
    end

    // Output decoder: Moore per state, except JUMP's PC strobes which follow the branch condition
    always_comb begin
        ld_PC                    = 1'b0;
        ld_IR                    = 1'b0;
        ld_DI                    = 1'b0;
        ld_TR                    = 1'b0;
        ld_ALU                   = 1'b0;
        ld_CZN                   = 1'b0;
        sel_MEM_src_PC           = 1'b0;
        sel_MEM_src_TR           = 1'b0;
        mem_write                = 1'b0;
        sel_IR_3_2               = 1'b0;
        sel_IR_4_3               = 1'b0;
        write_reg_en             = 1'b0;
        sel_RF_write_src_TR_12_5 = 1'b0;
        sel_writeSRC_reg1        = 1'b0;
        sel_writeSRC_ALU         = 1'b0;
        sel_ALU_src_reg1         = 1'b0;
        sel_ALU_src_TR           = 1'b0;
        sel_CZN_src_ALU          = 1'b0;
        sel_CZN_src_RF           = 1'b0;
        sel_PC_src_JUMP          = 1'b0;
        instr_done               = 1'b0;
        if (rst) begin
            case (r_state)
                S_FETCH: begin
                    sel_MEM_src_PC = 1'b1;
                    ld_IR          = 1'b1;
                    ld_DI          = 1'b1;
                    ld_PC          = 1'b1;
                end
                S_DECODE: ;
                S_FETCH2: begin
                    sel_MEM_src_PC = 1'b1;
                    ld_TR          = 1'b1;
                    ld_PC          = 1'b1;
                end
                S_MEMRD: begin
                    sel_MEM_src_TR = 1'b1;
                    ld_TR          = 1'b1;
                end
                S_WB_IMM: begin
                    sel_IR_4_3               = 1'b1;
                    sel_RF_write_src_TR_12_5 = 1'b1;
                    write_reg_en             = 1'b1;
                    instr_done               = 1'b1;
                end
                S_MEMWR: begin
                    sel_MEM_src_TR = 1'b1;
                    sel_IR_4_3     = 1'b1;
                    mem_write      = 1'b1;
                    instr_done     = 1'b1;
                end
                S_JUMP: begin
                    instr_done      = 1'b1;
                    sel_PC_src_JUMP = w_taken;
                    ld_PC           = w_taken;
                end
                S_MOV: begin
                    sel_IR_3_2        = 1'b1;
                    sel_writeSRC_reg1 = 1'b1;
                    write_reg_en      = 1'b1;
                    instr_done        = 1'b1;
                end
                S_EXEC: begin
                    sel_IR_3_2       = 1'b1;
                    sel_ALU_src_reg1 = 1'b1;
                    ld_ALU           = 1'b1;
                    ld_CZN           = 1'b1;
                    sel_CZN_src_ALU  = 1'b1;
                end
                S_ALU_WB: begin
                    sel_IR_3_2       = 1'b1;
                    sel_writeSRC_ALU = 1'b1;
                    write_reg_en     = 1'b1;
                    instr_done       = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multicycle control unit for the 8-bit-word, 13-bit-address accumulator-free CPU. It owns the instruction-sequencing FSM and drives every load/select/enable strobe consumed by the CPU data path. Inputs are the opcode and register fields captured in IR/DI and the CZN flag register. Outputs are purely control; it touches no data.

## Interface
Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- ir  in  8  IR contents; opcode in ir[7:5]
- di  in  5  DI contents; dst-register field di[4:3], jump condition di[2:1]
- czn  in  3  flag register; [0]=C, [1]=Z, [2]=N
- ld_PC, ld_IR, ld_DI, ld_TR, ld_ALU, ld_CZN  out  1 each  register loads
- sel_MEM_src_PC, sel_MEM_src_TR  out  1 each  memory address source, one-hot when addressing
- mem_write  out  1  memory write strobe; data comes from register-file read port 2
- sel_IR_3_2, sel_IR_4_3  out  1 each  register-file dst/read2 field select
- write_reg_en  out  1  register-file write enable
- sel_RF_write_src_TR_12_5, sel_writeSRC_reg1, sel_writeSRC_ALU  out  1 each  RF write-data source
- sel_ALU_src_reg1, sel_ALU_src_TR  out  1 each  ALU operand-1 source
- sel_CZN_src_ALU, sel_CZN_src_RF  out  1 each  flag source; sel_CZN_src_RF is tied 0
- sel_PC_src_JUMP  out  1  PC input = TR (1) or PC+1 (0)
- instr_done  out  1  one-cycle pulse in the last state of every instruction

## Operation
- ISA decoded from ir[7:5]. 000 LDI: Rd<=imm. 001 LDA: Rd<=mem[addr]. 010 STA: mem[addr]<=Rd. 011 JMP: PC<=addr if cond. 10x MOV: R[ir3:2]<=R[ir1:0]. 11x ALU: R[ir3:2]<=R[ir3:2] op R[ir1:0], flags updated.
- 000–011 are two-byte: addr/imm = {byte2, ir[4:0]} held in TR; Rd=di[4:3] and cond=di[2:1] alias address bits [4:3]/[2:1] (ISA constraint, assembler's job).
- Jump cond: 00 always, 01 C, 10 Z, 11 N.
- States and asserted outputs (all others 0):
  - FETCH: sel_MEM_src_PC, ld_IR, ld_DI, ld_PC (PC+1) -> DECODE
  - DECODE: none -> FETCH2 for 000–011, MOV for 10x, EXEC for 11x
  - FETCH2: sel_MEM_src_PC, ld_TR, ld_PC -> WB_IMM(000), MEMRD(001), MEMWR(010), JUMP(011)
  - MEMRD: sel_MEM_src_TR, ld_TR (TR[12:5]<=mem[TR]) -> WB_IMM
  - WB_IMM: sel_IR_4_3, sel_RF_write_src_TR_12_5, write_reg_en, instr_done -> FETCH
  - MEMWR: sel_MEM_src_TR, sel_IR_4_3, mem_write, instr_done -> FETCH
  - JUMP: instr_done; if cond true, sel_PC_src_JUMP and ld_PC -> FETCH
  - MOV: sel_IR_3_2, sel_writeSRC_reg1, write_reg_en, instr_done -> FETCH
  - EXEC: sel_IR_3_2, sel_ALU_src_reg1, ld_ALU, ld_CZN, sel_CZN_src_ALU -> ALU_WB
  - ALU_WB: sel_IR_3_2, sel_writeSRC_ALU, write_reg_en, instr_done -> FETCH
- Outputs Moore-decoded from state, except JUMP's two strobes, which are combinational on di and czn.
- Any unreachable state encoding -> FETCH, outputs 0.

## Timing
- Reset: state=FETCH; every output 0 while rst low. First FETCH strobes in the first cycle after rst deasserts.
- Reset mid-instruction aborts it; no partial write is asserted after rst falls.
- Cycles per instruction, counted FETCH to instr_done inclusive: MOV 3, ALU 4, LDI 4, STA 4, JMP 4, LDA 5.
- At most one RF-write source, one memory-address source and one ALU source is high in any cycle.
- sel_PC_src_JUMP=0 in every state but JUMP, so every ld_PC outside JUMP loads PC+1.
- czn is sampled in JUMP only; flags written in EXEC are visible to a JMP that immediately follows.

## Structure
- cpu_pkg holds: the state enum, opcode constants (OP_LDI..OP_ALU), and cond codes.
- Sub-module branch_cond: combinational (di[2:1], czn) -> taken.
- The rest is one FSM: state register plus an output decoder.

## Test plan
- Reset: hold rst=0 for 3 cycles -> all outputs 0. Release -> FETCH strobes (ld_IR, ld_DI, ld_PC, sel_MEM_src_PC) next cycle.
- ir=8'b1000_0110 (MOV R1<=R2) -> FETCH, DECODE, MOV. MOV shows sel_IR_3_2, sel_writeSRC_reg1, write_reg_en, instr_done. Next state FETCH.
- ir=8'b0010_1000, di=5'b01000 (LDA) -> 5 states; MEMRD asserts sel_MEM_src_TR and ld_TR; WB_IMM asserts sel_IR_4_3 and write_reg_en.
- JMP with di[2:1]=10: czn=3'b010 -> ld_PC and sel_PC_src_JUMP high in JUMP. czn=3'b000 -> both 0 in JUMP, instr_done still 1.
- ALU followed by JMP on C: ALU run produces C=1; czn driven to 3'b001 after EXEC -> jump taken.
- Drop rst during EXEC -> outputs 0 immediately, no ALU_WB write; restart at FETCH.
